// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and a baud divider helper.
// Used by uart_tx_frame today and intended for the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  // Rounded to the nearest integer divider.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, held at 0 otherwise.
// tick_o is high during the terminal-count cycle.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == TERM) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == TERM);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with baud divider, DATA_W data bits, 1/2 stop bits and valid/ready input.
// Optional parity bit is compiled in by defining UART_TX_PARITY_EN.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic              tx,
  output logic              busy_o,
  output logic              end_o
);

  localparam int BW = $clog2(DATA_W + 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              tx_q, tx_d;
  logic              bit_done;

`ifdef UART_TX_PARITY_EN
  logic parity_q, parity_d;
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
`endif

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .CNT_W       (CNT_W)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q != ST_IDLE),
    .tick_o(bit_done)
  );

  // tx_d is derived from the next state so the pin changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d      = 1'b1;
        bit_cnt_d = '0;
        if (valid_i) begin
          shreg_d = data_i;
          state_d = ST_START;
          tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^data_i) ^ (PARITY_ODD != 0);
`endif
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          tx_d      = shreg_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = ST_PARITY;
            tx_d      = parity_q;
`else
            state_d   = ST_STOP;
            tx_d      = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shreg_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_done) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          if (bit_cnt_q == BW'(STOP_BITS - 1)) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
        tx_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx      = tx_q;
  assign ready_o = (state_q == ST_IDLE);
  assign busy_o  = (state_q != ST_IDLE);
  assign end_o   = (state_q == ST_STOP) && bit_done && (bit_cnt_q == BW'(STOP_BITS - 1));

endmodule
